// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared definitions for the FPU issue scoreboard.
//   REG_W_DEF : default register tag width (bank bit + 5-bit index)
//   BANK_BIT  : position of the register-bank bit inside a tag
//   reg_tag_t : tag type at the default width
//   tag_bank  : helper returning the bank bit of a tag
package fpu_pkg;

  localparam int REG_W_DEF = 6;
  localparam int BANK_BIT  = 5;

  typedef logic [REG_W_DEF-1:0] reg_tag_t;

  function automatic logic tag_bank(input reg_tag_t tag);
    return tag[BANK_BIT];
  endfunction

endpackage

// File: rtl/fpu_long_tracker.sv
// fpu_long_tracker -- busy table and outstanding counter for long-latency
// FPU ops (div/sqrt).
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   set_en, set_tag    : accepted long op marks its destination busy
//   clr_en, clr_tag    : long op writeback clears its destination
//   busy               : one busy bit per register tag
//   count              : number of outstanding long ops
//   full               : count has reached MAX_LONG
module fpu_long_tracker
  import fpu_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_LONG = 4,
  parameter int CNT_W    = $clog2(MAX_LONG + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en,
  input  logic [REG_W-1:0]      set_tag,
  input  logic                  clr_en,
  input  logic [REG_W-1:0]      clr_tag,
  output logic [2**REG_W-1:0]   busy,
  output logic [CNT_W-1:0]      count,
  output logic                  full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LONG);

  logic set_ok;
  logic clr_hit;

  assign full    = (count == MAX_CNT);
  // The count never wraps: sets beyond MAX_LONG and clears of idle tags
  // are dropped, so count always equals the number of busy bits.
  assign set_ok  = set_en && !full;
  assign clr_hit = clr_en && busy[clr_tag];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy  <= '0;
      count <= '0;
    end else begin
      if (clr_hit) busy[clr_tag] <= 1'b0;
      if (set_ok)  busy[set_tag] <= 1'b1;
      case ({set_ok, clr_hit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard -- issue-stage hazard check for an FPU with a fixed
// PIPE_DEPTH-stage pipe and up to MAX_LONG outstanding long-latency ops.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   issue_valid_i     : instruction offered this cycle
//   issue_long_i      : offered instruction is long-latency
//   issue_dest_i      : destination tag
//   issue_src_i       : packed source tags, src k at [k*REG_W +: REG_W]
//   issue_src_en_i    : per-source "operand used" mask
//   long_done_i       : a long op writes back this cycle
//   long_done_tag_i   : destination tag of that long op
//   hazard_o          : combinational stall for the offered instruction
//   long_busy_o       : at least one long op outstanding
// Configuration macro: FPU_SCOREBOARD_FWD_EN -- when defined, the last pipe
// stage (writeback) is forwarded by the datapath and excluded from RAW checks.
//
// Handshake: issue_valid_i is the offer and !hazard_o is the ready; an
// instruction is accepted on a clock edge exactly when issue_valid_i=1 and
// hazard_o=0. A stalled offer changes no state and may be re-offered.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int NUM_SRC    = 3,
  parameter int PIPE_DEPTH = 2,
  parameter int MAX_LONG   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic                     issue_long_i,
  input  logic [REG_W-1:0]         issue_dest_i,
  input  logic [NUM_SRC*REG_W-1:0] issue_src_i,
  input  logic [NUM_SRC-1:0]       issue_src_en_i,
  input  logic                     long_done_i,
  input  logic [REG_W-1:0]         long_done_tag_i,
  output logic                     hazard_o,
  output logic                     long_busy_o
);

  localparam int CNT_W = $clog2(MAX_LONG + 1);
`ifdef FPU_SCOREBOARD_FWD_EN
  localparam int CHECK_STAGES = PIPE_DEPTH - 1;
`else
  localparam int CHECK_STAGES = PIPE_DEPTH;
`endif

  logic                 pipe_valid [PIPE_DEPTH];
  logic [REG_W-1:0]     pipe_dest  [PIPE_DEPTH];
  logic [2**REG_W-1:0]  busy;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 raw_haz;
  logic                 waw_haz;
  logic                 struct_haz;
  logic                 accept;
  logic [REG_W-1:0]     src_tag;

  fpu_long_tracker #(
    .REG_W    (REG_W),
    .MAX_LONG (MAX_LONG),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .set_en  (accept && issue_long_i),
    .set_tag (issue_dest_i),
    .clr_en  (long_done_i),
    .clr_tag (long_done_tag_i),
    .busy    (busy),
    .count   (count),
    .full    (full)
  );

  // RAW: any used source against checked pipe stages and busy long tags.
  // A tag completing this cycle is still busy here; no bypass.
  always_comb begin
    raw_haz = 1'b0;
    src_tag = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (issue_src_en_i[k]) begin
        src_tag = issue_src_i[k*REG_W +: REG_W];
        if (busy[src_tag]) raw_haz = 1'b1;
        for (int s = 0; s < CHECK_STAGES; s++) begin
          if (pipe_valid[s] && (pipe_dest[s] == src_tag)) raw_haz = 1'b1;
        end
      end
    end
  end

  assign waw_haz    = busy[issue_dest_i];
  assign struct_haz = issue_long_i && full;
  assign hazard_o   = issue_valid_i && (raw_haz || waw_haz || struct_haz);
  assign accept     = issue_valid_i && !hazard_o;
  assign long_busy_o = (count != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_dest[s]  <= '0;
      end
    end else begin
      pipe_valid[0] <= accept && !issue_long_i;
      pipe_dest[0]  <= issue_dest_i;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_dest[s]  <= pipe_dest[s-1];
      end
    end
  end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard -- directed bench for fpu_scoreboard (default params).
// Honours FPU_SCOREBOARD_FWD_EN for the expected pipe-hazard duration.
module tb_fpu_scoreboard;

  localparam int REG_W      = 6;
  localparam int NUM_SRC    = 3;
  localparam int PIPE_DEPTH = 2;
  localparam int MAX_LONG   = 4;
`ifdef FPU_SCOREBOARD_FWD_EN
  localparam int PIPE_HAZ_CYCLES = PIPE_DEPTH - 1;
`else
  localparam int PIPE_HAZ_CYCLES = PIPE_DEPTH;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     issue_valid;
  logic                     issue_long;
  logic [REG_W-1:0]         issue_dest;
  logic [NUM_SRC*REG_W-1:0] issue_src;
  logic [NUM_SRC-1:0]       issue_src_en;
  logic                     long_done;
  logic [REG_W-1:0]         long_done_tag;
  logic                     hazard;
  logic                     long_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpu_scoreboard #(
    .REG_W      (REG_W),
    .NUM_SRC    (NUM_SRC),
    .PIPE_DEPTH (PIPE_DEPTH),
    .MAX_LONG   (MAX_LONG)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .issue_valid_i   (issue_valid),
    .issue_long_i    (issue_long),
    .issue_dest_i    (issue_dest),
    .issue_src_i     (issue_src),
    .issue_src_en_i  (issue_src_en),
    .long_done_i     (long_done),
    .long_done_tag_i (long_done_tag),
    .hazard_o        (hazard),
    .long_busy_o     (long_busy)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [NUM_SRC*REG_W-1:0] pack_src(
    input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1,
    input logic [REG_W-1:0] s2);
    return {s2, s1, s0};
  endfunction

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time
  // unit later, well away from the next rising edge.
  task automatic drive(input logic v, input logic l, input logic [REG_W-1:0] d,
                       input logic [NUM_SRC*REG_W-1:0] s,
                       input logic [NUM_SRC-1:0] en,
                       input logic dn, input logic [REG_W-1:0] dt);
    @(negedge clk);
    issue_valid   = v;
    issue_long    = l;
    issue_dest    = d;
    issue_src     = s;
    issue_src_en  = en;
    long_done     = dn;
    long_done_tag = dt;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic done_tag(input logic [REG_W-1:0] t);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, t);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard);
    end
    n_checks++;
    if (long_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_long_busy: got %b expected 0", long_busy);
    end
  endtask

  task automatic test_pipe_raw;
    drive(1'b1, 1'b0, 6'h05, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL pipe_issue: got %b expected 0", hazard);
    end
    for (int i = 0; i < PIPE_HAZ_CYCLES; i++) begin
      drive(1'b1, 1'b0, 6'h10, pack_src(6'h05, 6'h00, 6'h00), 3'b001, 1'b0, '0);
      n_checks++;
      if (hazard !== 1'b1) begin
        n_fail++; $display("FAIL pipe_raw_cycle%0d: got %b expected 1", i, hazard);
      end
    end
    drive(1'b1, 1'b0, 6'h10, pack_src(6'h05, 6'h00, 6'h00), 3'b001, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL pipe_raw_clear: got %b expected 0", hazard);
    end
    idle(3);
  endtask

  task automatic test_long_raw;
    drive(1'b1, 1'b1, 6'h21, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL long_issue: got %b expected 0", hazard);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 6'h30, pack_src(6'h00, 6'h21, 6'h00), 3'b010, 1'b0, '0);
      n_checks++;
      if (hazard !== 1'b1 || long_busy !== 1'b1) begin
        n_fail++; $display("FAIL long_raw_wait%0d: got haz=%b busy=%b expected haz=1 busy=1",
                           i, hazard, long_busy);
      end
    end
    // WAW against the busy destination.
    drive(1'b1, 1'b0, 6'h21, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL long_waw: got %b expected 1", hazard);
    end
    // Done cycle still hazards (no bypass).
    drive(1'b1, 1'b0, 6'h30, pack_src(6'h00, 6'h21, 6'h00), 3'b010, 1'b1, 6'h21);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL long_done_cycle: got %b expected 1", hazard);
    end
    drive(1'b1, 1'b0, 6'h30, pack_src(6'h00, 6'h21, 6'h00), 3'b010, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0 || long_busy !== 1'b0) begin
      n_fail++; $display("FAIL long_after_done: got haz=%b busy=%b expected haz=0 busy=0",
                         hazard, long_busy);
    end
    idle(3);
  endtask

  task automatic test_structural;
    for (int t = 1; t <= MAX_LONG; t++) begin
      drive(1'b1, 1'b1, 6'(t), '0, 3'b000, 1'b0, '0);
      n_checks++;
      if (hazard !== 1'b0) begin
        n_fail++; $display("FAIL struct_fill_tag%0d: got %b expected 0", t, hazard);
      end
    end
    drive(1'b1, 1'b1, 6'h05, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL struct_full_long: got %b expected 1", hazard);
    end
    drive(1'b1, 1'b0, 6'h09, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL struct_short_ok: got %b expected 0", hazard);
    end
    // No hazard without a valid offer, even with matching sources.
    drive(1'b0, 1'b1, 6'h01, pack_src(6'h01, 6'h02, 6'h03), 3'b111, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL struct_no_valid: got %b expected 0", hazard);
    end
    for (int t = 1; t <= MAX_LONG; t++) done_tag(6'(t));
    idle(1);
    n_checks++;
    if (long_busy !== 1'b0) begin
      n_fail++; $display("FAIL struct_drain: got %b expected 0", long_busy);
    end
    idle(2);
  endtask

  task automatic test_same_cycle;
    drive(1'b1, 1'b1, 6'h01, '0, 3'b000, 1'b0, '0);
    drive(1'b1, 1'b1, 6'h02, '0, 3'b000, 1'b0, '0);
    // Long issue of tag 3 together with done of tag 1: count stays 2.
    drive(1'b1, 1'b1, 6'h03, '0, 3'b000, 1'b1, 6'h01);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL same_issue: got %b expected 0", hazard);
    end
    drive(1'b1, 1'b0, 6'h0A, pack_src(6'h01, 6'h00, 6'h00), 3'b001, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL same_tag1_cleared: got %b expected 0", hazard);
    end
    drive(1'b1, 1'b0, 6'h0B, pack_src(6'h03, 6'h00, 6'h00), 3'b001, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL same_tag3_busy: got %b expected 1", hazard);
    end
    // Count is 2, so two more fit and the next is structurally stalled.
    drive(1'b1, 1'b1, 6'h04, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL same_fill3: got %b expected 0", hazard);
    end
    drive(1'b1, 1'b1, 6'h05, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL same_fill4: got %b expected 0", hazard);
    end
    drive(1'b1, 1'b1, 6'h06, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL same_full: got %b expected 1", hazard);
    end
    done_tag(6'h02);
    done_tag(6'h03);
    done_tag(6'h04);
    done_tag(6'h05);
    idle(1);
    n_checks++;
    if (long_busy !== 1'b0) begin
      n_fail++; $display("FAIL same_drain: got %b expected 0", long_busy);
    end
    idle(2);
  endtask

  task automatic test_src_mask;
    drive(1'b1, 1'b1, 6'h07, '0, 3'b000, 1'b0, '0);
    drive(1'b1, 1'b0, 6'h12, pack_src(6'h11, 6'h07, 6'h07), 3'b001, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL mask_disabled: got %b expected 0", hazard);
    end
    drive(1'b1, 1'b0, 6'h13, pack_src(6'h11, 6'h00, 6'h07), 3'b100, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL mask_enabled_src2: got %b expected 1", hazard);
    end
    done_tag(6'h07);
    idle(3);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 6'h0B, '0, 3'b000, 1'b0, '0);
    drive(1'b1, 1'b1, 6'h0C, '0, 3'b000, 1'b0, '0);
    idle(1);
    n_checks++;
    if (long_busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", long_busy);
    end
    rst_n = 1'b0;
    idle(1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (long_busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_busy_after: got %b expected 0", long_busy);
    end
    drive(1'b1, 1'b0, 6'h14, pack_src(6'h0B, 6'h0C, 6'h00), 3'b011, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL rmid_no_stale: got %b expected 0", hazard);
    end
    done_tag(6'h0B);
    idle(1);
    n_checks++;
    if (long_busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_late_done: got %b expected 0", long_busy);
    end
    // Count must still be 0: exactly MAX_LONG long ops fit.
    for (int t = 1; t <= MAX_LONG; t++) begin
      drive(1'b1, 1'b1, 6'(6'h20 + t), '0, 3'b000, 1'b0, '0);
      n_checks++;
      if (hazard !== 1'b0) begin
        n_fail++; $display("FAIL rmid_refill%0d: got %b expected 0", t, hazard);
      end
    end
    drive(1'b1, 1'b1, 6'h30, '0, 3'b000, 1'b0, '0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL rmid_refull: got %b expected 1", hazard);
    end
    idle(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n         = 1'b0;
    issue_valid   = 1'b0;
    issue_long    = 1'b0;
    issue_dest    = '0;
    issue_src     = '0;
    issue_src_en  = '0;
    long_done     = 1'b0;
    long_done_tag = '0;
    test_reset();
    test_pipe_raw();
    test_long_raw();
    test_structural();
    test_same_cycle();
    test_src_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
